mult_seq_control: RTL

- Parametrised sequencer for the add-shift multiplier datapath. Generalises the 8-bit controller to any operand WIDTH.
- Adds a bit-iteration counter, conditional add/sub driven by the multiplier LSB (M) and a two's-complement correction subtract on the final bit.
- Provides busy/done status with a Run-release handshake.
- Sits between the switch/button inputs and the A/B shift-register + adder datapath.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_seq_control_iter_counter.sv | 46 ++++
 rtl/mult_seq_control.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the add-shift multiplier sequencer.
//   mult_state_t : sequencer state encoding
//   cnt_w()      : width of the bit-iteration counter for a given operand width
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mult_seq_control_iter_counter.sv
// Bit-iteration counter for the multiplier sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over inc)
//   inc        : advance by one
//   cnt        : current iteration index
//   last       : cnt is at the final iteration (WIDTH-1)
module iter_counter
    import mult_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/mult_seq_control.sv
// Sequencer for the add-shift multiplier datapath (A/B shift registers + adder).
//   Clk, Reset_n       : clock, asynchronous active-low reset
//   Run                : start request (level, synchronised upstream)
//   ClearA_LoadB       : in IDLE, clear A/X and load B
//   M                  : current multiplier LSB (B[0])
//   clr_ld, clear_a    : datapath load / clear strobes
//   add, sub, shift    : datapath operation strobes
//   busy, done         : status (START..last SHIFT / HOLD)
//   bit_idx            : current iteration index
//
// state | meaning
// IDLE  | waiting for Run; ClearA_LoadB passes through to clr_ld
// START | clear A/X, reset iteration counter
// EVAL  | add (or final-bit subtract) S into A when M=1
// SHIFT | arithmetic right shift of X:A:B, advance iteration
// HOLD  | result valid; wait for Run to be released
module mult_seq_control
    import mult_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  bit SIGNED = 1'b1,
    localparam int CW     = cnt_w(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Run,
    input  logic          ClearA_LoadB,
    input  logic          M,
    output logic          clr_ld,
    output logic          clear_a,
    output logic          add,
    output logic          sub,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bit_idx
);

    mult_state_t   state_q;
    mult_state_t   state_d;
    logic          ready_q;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_last;
    logic [CW-1:0] cnt;

    iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_clr = 1'b1;
                state_d = EVAL;
            end
            EVAL: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_last) begin
                    state_d = HOLD;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = EVAL;
                end
            end
            HOLD: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ready_q keeps clr_ld quiet during the first cycle after reset release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        clr_ld  = 1'b0;
        clear_a = 1'b0;
        add     = 1'b0;
        sub     = 1'b0;
        shift   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                clr_ld = ClearA_LoadB & ready_q;
            end
            START: begin
                clear_a = 1'b1;
                busy    = 1'b1;
            end
            EVAL: begin
                busy = 1'b1;
                // The multiplier sign bit carries negative weight, so the
                // final partial product is subtracted in signed mode.
                if (M) begin
                    if (SIGNED && cnt_last) begin
                        sub = 1'b1;
                    end else begin
                        add = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
            end
            HOLD: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bit_idx = cnt;

endmodule
